// File: rtl/mult_accum_stage.sv
// mult_accum_stage: first register stage after the 4x4 array multiplier.
// Sums a group of product beats, delimited by in_last, into a wide
// accumulator. The finished group sum, the saturating beat count and the
// sticky overflow flag are presented on a registered valid/ready output.
module mult_accum_stage #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               beat_acc;
    logic [ACC_W:0]     prod_ext;
    logic [ACC_W:0]     sum_ext;
    logic [CNT_W-1:0]   cnt_inc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a last beat closes the group, the output handshake reopens it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (beat_acc && in_last) state_d = HOLD;
            HOLD:    if (out_ready)           state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // FSM outputs: ready depends only on the registered state
    always_comb begin
        in_ready = (state_q == ACCUM);
    end

    // Adder with carry-out, and the saturating beat count
    always_comb begin
        beat_acc = in_valid && (state_q == ACCUM);
        prod_ext = '0;
        prod_ext[PROD_W-1:0] = in_prod;
        sum_ext  = {1'b0, acc_q} + prod_ext;
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Datapath next values: accumulate, close a group, release a held result
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (beat_acc) begin
            if (in_last) begin
                out_sum_d   = sum_ext[ACC_W-1:0];
                out_ovf_d   = ovf_q | sum_ext[ACC_W];
                out_count_d = cnt_inc;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
                ovf_d = ovf_q | sum_ext[ACC_W];
                cnt_d = cnt_inc;
            end
        end
        if ((state_q == HOLD) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
